// File: rtl/data_l1_cache_nway_if.sv
// Bus interfaces for the N-way L1 data cache: core-side request bus and
// memory-side beat bus. The cache is slave on the core bus, master on memory.
interface data_l1_core_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   i_addr;
  logic                    i_re;
  logic                    i_we;
  logic [DATA_WIDTH/8-1:0] i_be;
  logic [DATA_WIDTH-1:0]   i_wdata;
  logic [DATA_WIDTH-1:0]   o_rdata;
  logic                    o_busy;
  logic                    o_hit;
  logic                    i_flush;

  modport master (output i_addr, i_re, i_we, i_be, i_wdata, i_flush,
                  input  o_rdata, o_busy, o_hit);
  modport slave  (input  i_addr, i_re, i_we, i_be, i_wdata, i_flush,
                  output o_rdata, o_busy, o_hit);
endinterface

interface data_l1_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   o_mem_addr;
  logic                    o_mem_re;
  logic                    o_mem_we;
  logic [DATA_WIDTH/8-1:0] o_mem_be;
  logic [DATA_WIDTH-1:0]   o_mem_wdata;
  logic [DATA_WIDTH-1:0]   i_mem_rdata;
  logic                    i_mem_ready;

  modport master (output o_mem_addr, o_mem_re, o_mem_we, o_mem_be, o_mem_wdata,
                  input  i_mem_rdata, i_mem_ready);
  modport slave  (input  o_mem_addr, o_mem_re, o_mem_we, o_mem_be, o_mem_wdata,
                  output i_mem_rdata, i_mem_ready);
endinterface

// File: rtl/data_l1_cache_nway.sv
// N-way set-associative write-through, no-write-allocate L1 data cache with
// multi-word line refill, ready-handshaked memory beats and whole-cache flush.
module data_l1_cache_nway #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  data_l1_core_if.slave core,
  data_l1_mem_if.master mem
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_B  = $clog2(BYTES);
  localparam int WIDX_B = $clog2(LINE_WORDS);
  localparam int SET_B  = $clog2(SETS);
  localparam int LINE_B = OFF_B + WIDX_B;
  localparam int TAG_W  = ADDR_WIDTH - LINE_B - SET_B;
  localparam int WI_W   = (WIDX_B > 0) ? WIDX_B : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~((ADDR_WIDTH'(1) << OFF_B) - ADDR_WIDTH'(1));
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << LINE_B) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, FLUSH} state_t;

  function automatic logic [SET_B-1:0] set_of(input logic [ADDR_WIDTH-1:0] a);
    return a[LINE_B +: SET_B];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1 -: TAG_W];
  endfunction

  function automatic logic [WI_W-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return (WIDX_B == 0) ? '0 : WI_W'(a >> OFF_B);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [BYTES-1:0]      be);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < BYTES; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
  logic [SETS-1:0]       valid_q [WAYS];
  logic [WAY_W-1:0]      vptr_q  [SETS];

  state_t                state_q;
  logic [WI_W-1:0]       beat_q;
  logic [WI_W-1:0]       word_q;
  logic [WAY_W-1:0]      way_q;
  logic [SET_B-1:0]      set_q;
  logic [SET_B-1:0]      flush_q;
  logic [TAG_W-1:0]      tag_lat_q;
  logic                  wr_hit_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_re_q;
  logic                  mem_we_q;
  logic [BYTES-1:0]      mem_be_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [SET_B-1:0]      req_set;
  logic [TAG_W-1:0]      req_tag;
  logic [WI_W-1:0]       req_word;
  logic                  hit_any;
  logic [WAY_W-1:0]      hit_way;
  logic                  inv_any;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      victim;
  logic                  lookup_hit;
  logic                  last_beat;

  assign req_set  = set_of(core.i_addr);
  assign req_tag  = tag_of(core.i_addr);
  assign req_word = word_of(core.i_addr);

  // Lowest-index matching way wins the hit; lowest invalid way is the preferred victim.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && valid_q[w][req_set] && (tag_q[w][req_set] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_any && !valid_q[w][req_set]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim     = inv_any ? inv_way : vptr_q[req_set];
  assign lookup_hit = (state_q == IDLE) && (core.i_re || core.i_we) && hit_any;
  assign last_beat  = (beat_q == WI_W'(LINE_WORDS - 1));

  assign core.o_hit   = lookup_hit;
  assign core.o_rdata = lookup_hit ? data_q[hit_way][req_set][req_word] : '0;
  assign core.o_busy  = (state_q != IDLE) || (core.i_re && !lookup_hit) ||
                        core.i_we || core.i_flush;

  assign mem.o_mem_addr  = mem_addr_q;
  assign mem.o_mem_re    = mem_re_q;
  assign mem.o_mem_we    = mem_we_q;
  assign mem.o_mem_be    = mem_be_q;
  assign mem.o_mem_wdata = mem_wdata_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      word_q      <= '0;
      way_q       <= '0;
      set_q       <= '0;
      flush_q     <= '0;
      tag_lat_q   <= '0;
      wr_hit_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) vptr_q[s] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (core.i_flush) begin
            state_q <= FLUSH;
            flush_q <= '0;
          end else if (core.i_we) begin
            state_q     <= WRITE;
            set_q       <= req_set;
            word_q      <= req_word;
            way_q       <= hit_way;
            wr_hit_q    <= hit_any;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= core.i_addr & WORD_MASK;
            mem_be_q    <= core.i_be;
            mem_wdata_q <= core.i_wdata;
          end else if (core.i_re && !hit_any) begin
            state_q    <= REFILL;
            set_q      <= req_set;
            tag_lat_q  <= req_tag;
            way_q      <= victim;
            beat_q     <= '0;
            mem_re_q   <= 1'b1;
            mem_addr_q <= core.i_addr & LINE_MASK;
          end
        end
        REFILL: begin
          if (mem.i_mem_ready) begin
            if (last_beat) begin
              valid_q[way_q][set_q] <= 1'b1;
              vptr_q[set_q]         <= (WAYS == 1) ? '0 : vptr_q[set_q] + WAY_W'(1);
              mem_re_q              <= 1'b0;
              mem_addr_q            <= '0;
              state_q               <= IDLE;
            end else begin
              beat_q     <= beat_q + WI_W'(1);
              mem_addr_q <= mem_addr_q + ADDR_WIDTH'(BYTES);
            end
          end
        end
        WRITE: begin
          if (mem.i_mem_ready) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            state_q     <= IDLE;
          end
        end
        FLUSH: begin
          for (int w = 0; w < WAYS; w++) valid_q[w][flush_q] <= 1'b0;
          vptr_q[flush_q] <= '0;
          if (flush_q == SET_B'(SETS - 1)) state_q <= IDLE;
          else                             flush_q <= flush_q + SET_B'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; its validity is owned by valid_q.
  always_ff @(posedge i_clock) begin
    if ((state_q == REFILL) && mem.i_mem_ready) begin
      data_q[way_q][set_q][beat_q] <= mem.i_mem_rdata;
      if (last_beat) tag_q[way_q][set_q] <= tag_lat_q;
    end else if ((state_q == WRITE) && mem.i_mem_ready && wr_hit_q) begin
      data_q[way_q][set_q][word_q] <= merge_bytes(data_q[way_q][set_q][word_q],
                                                  mem_wdata_q, mem_be_q);
    end
  end
endmodule

// File: tb/tb_data_l1_cache_nway.sv
// Scoreboard bench for data_l1_cache_nway: directed scenarios followed by
// random traffic, checked against a line-residency model and a reference memory.
module tb_data_l1_cache_nway;
  localparam int AW = 32, DW = 32, WAYS = 2, SETS = 64, LW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_l1_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) core_bus ();
  data_l1_mem_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  data_l1_cache_nway #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAYS(WAYS),
                       .SETS(SETS), .LINE_WORDS(LW)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .core(core_bus),
    .mem(mem_bus)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } mem_txn_t;

  int errors = 0;
  int checks = 0;

  mem_txn_t    exp_mem[$];
  logic [31:0] exp_rd[$];

  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] mem_model [logic [31:0]];

  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  int          m_vptr  [SETS];

  int lat_mode  = 0;
  int fixed_lat = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : init_word(a);
  endfunction

  // Address decomposition in plain arithmetic: a line is LW words of 4 bytes.
  function automatic int set_idx(input logic [31:0] a);
    return int'((a / (4 * LW)) % SETS);
  endfunction

  function automatic int unsigned tag_val(input logic [31:0] a);
    return a / (4 * LW * SETS);
  endfunction

  function automatic bit model_resident(input logic [31:0] a);
    int s = set_idx(a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_val(a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input logic [31:0] a);
    int s = set_idx(a);
    int v = -1;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) v = m_vptr[s];
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = tag_val(a);
    m_vptr[s]     = (m_vptr[s] + 1) % WAYS;
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_vptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  function automatic int pick_lat();
    return (lat_mode == 0) ? fixed_lat : int'($urandom_range(0, 3));
  endfunction

  // Memory responder: per-beat latency, write beats update the backing memory.
  initial begin
    int  cnt = 0;
    int  cur_lat = 0;
    bit  fresh = 1'b1;
    mem_bus.i_mem_ready = 1'b0;
    mem_bus.i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_bus.i_mem_ready && (mem_bus.o_mem_re || mem_bus.o_mem_we)) begin
        if (mem_bus.o_mem_we)
          mem_model[mem_bus.o_mem_addr] = merge(mem_word(mem_bus.o_mem_addr),
                                                mem_bus.o_mem_wdata, mem_bus.o_mem_be);
        fresh = 1'b1;
      end
      @(posedge clk);
      #1;
      mem_bus.i_mem_rdata = mem_word(mem_bus.o_mem_addr);
      if (mem_bus.o_mem_re || mem_bus.o_mem_we) begin
        if (fresh) begin
          cur_lat = pick_lat();
          cnt     = 0;
          fresh   = 1'b0;
        end
        if (cnt >= cur_lat) mem_bus.i_mem_ready = 1'b1;
        else begin
          mem_bus.i_mem_ready = 1'b0;
          cnt++;
        end
      end else begin
        mem_bus.i_mem_ready = 1'b0;
        fresh = 1'b1;
      end
    end
  end

  // Memory-side monitor: every completed beat must match the next expected transaction.
  always @(negedge clk) begin
    mem_txn_t t;
    if (!rst && mem_bus.i_mem_ready && (mem_bus.o_mem_re || mem_bus.o_mem_we)) begin
      if (exp_mem.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_unexpected: got beat re=%0b we=%0b addr=%0h, none expected",
                 mem_bus.o_mem_re, mem_bus.o_mem_we, mem_bus.o_mem_addr);
      end else begin
        t = exp_mem.pop_front();
        check("mem_kind_we", {63'd0, mem_bus.o_mem_we}, {63'd0, t.we});
        check("mem_kind_re", {63'd0, mem_bus.o_mem_re}, {63'd0, !t.we});
        check("mem_addr", {32'd0, mem_bus.o_mem_addr}, {32'd0, t.addr});
        if (t.we) begin
          check("mem_be", {60'd0, mem_bus.o_mem_be}, {60'd0, t.be});
          check("mem_wdata", {32'd0, mem_bus.o_mem_wdata}, {32'd0, t.data});
        end
      end
    end
  end

  // Core-side monitor: a read completes in the cycle busy is low with i_re held.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && core_bus.i_re && !core_bus.i_we && !core_bus.o_busy) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rdata %0h, no read expected", core_bus.o_rdata);
      end else begin
        e = exp_rd.pop_front();
        check("rd_data", {32'd0, core_bus.o_rdata}, {32'd0, e});
        check("rd_hit", {63'd0, core_bus.o_hit}, 64'd1);
      end
    end
  end

  task automatic do_read(input logic [31:0] a, output int busy_cycles, output bit first_hit);
    bit   exp_hit;
    int   cyc;
    mem_txn_t t;
    logic [31:0] base;
    exp_hit = model_resident(a);
    base    = a & ~32'(4 * LW - 1);
    if (!exp_hit) begin
      for (int k = 0; k < LW; k++) begin
        t.we = 1'b0; t.addr = base + 32'(4 * k); t.be = '0; t.data = '0;
        exp_mem.push_back(t);
      end
      model_fill(a);
    end
    exp_rd.push_back(ref_word(a & ~32'h3));
    @(posedge clk); #1;
    core_bus.i_addr = a;
    core_bus.i_re   = 1'b1;
    busy_cycles = 0;
    first_hit   = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cyc == 0) first_hit = core_bus.o_hit;
      if (!core_bus.o_busy) break;
      busy_cycles++;
      cyc++;
      if (cyc > 300) begin
        check("rd_timeout", 64'(cyc), 64'd0);
        break;
      end
    end
    check("rd_first_hit", {63'd0, first_hit}, {63'd0, exp_hit});
    @(posedge clk); #1;
    core_bus.i_re = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          input bit also_re, output int we_cycles);
    mem_txn_t t;
    int cyc;
    t.we = 1'b1; t.addr = a & ~32'h3; t.be = be; t.data = d;
    exp_mem.push_back(t);
    ref_mem[a & ~32'h3] = merge(ref_word(a & ~32'h3), d, be);
    @(posedge clk); #1;
    core_bus.i_addr  = a;
    core_bus.i_be    = be;
    core_bus.i_wdata = d;
    core_bus.i_we    = 1'b1;
    core_bus.i_re    = also_re;
    we_cycles = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (mem_bus.o_mem_we) we_cycles++;
      if (mem_bus.o_mem_we && mem_bus.i_mem_ready) break;
      cyc++;
      if (cyc > 300) begin
        check("wr_timeout", 64'(cyc), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    core_bus.i_we = 1'b0;
    core_bus.i_re = 1'b0;
  endtask

  task automatic do_flush(output int cycles);
    model_clear();
    @(posedge clk); #1;
    core_bus.i_flush = 1'b1;
    @(posedge clk); #1;
    core_bus.i_flush = 1'b0;
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!core_bus.o_busy) break;
      cycles++;
      if (cycles > 500) begin
        check("flush_timeout", 64'(cycles), 64'd0);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int b, wc, n, cyc;
    bit h;
    logic [31:0] a;
    mem_txn_t t;
    int sets_pool[3] = '{0, 1, 5};

    rst = 1'b1;
    core_bus.i_addr = '0; core_bus.i_re = 1'b0; core_bus.i_we = 1'b0;
    core_bus.i_be = '0; core_bus.i_wdata = '0; core_bus.i_flush = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, core_bus.o_busy}, 64'd0);
    check("rst_hit", {63'd0, core_bus.o_hit}, 64'd0);
    check("rst_mem_re", {63'd0, mem_bus.o_mem_re}, 64'd0);
    check("rst_mem_we", {63'd0, mem_bus.o_mem_we}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_bus.o_mem_addr}, 64'd0);
    check("rst_mem_be_wdata", {28'd0, mem_bus.o_mem_be, mem_bus.o_mem_wdata}, 64'd0);

    lat_mode = 0; fixed_lat = 0;
    do_read(32'h100, b, h);
    check("first_refill_busy", 64'(b), 64'd5);
    do_read(32'h104, b, h);
    check("line_hit_busy", 64'(b), 64'd0);
    check("line_hit_flag", {63'd0, h}, 64'd1);

    do_read(32'h900, b, h);
    do_read(32'h1100, b, h);
    do_read(32'h900, b, h);
    check("evict_900_still_hit", {63'd0, h}, 64'd1);
    do_read(32'h100, b, h);
    check("evict_100_missed", {63'd0, h}, 64'd0);

    fixed_lat = 3;
    do_write(32'h104, 4'b0010, 32'hAABB_CCDD, 1'b0, wc);
    check("write_we_cycles", 64'(wc), 64'd4);
    fixed_lat = 0;
    do_read(32'h104, b, h);
    check("merged_read_hit", {63'd0, h}, 64'd1);

    do_write(32'h2000, 4'hF, 32'h1234_5678, 1'b0, wc);
    do_read(32'h2000, b, h);
    check("no_alloc_miss", {63'd0, h}, 64'd0);

    do_write(32'h108, 4'h0, 32'hDEAD_BEEF, 1'b0, wc);
    do_read(32'h108, b, h);

    do_flush(n);
    check("flush_cycles", 64'(n), 64'(SETS));
    do_read(32'h104, b, h);
    check("post_flush_miss", {63'd0, h}, 64'd0);

    // Reset in the middle of a refill, with beat 2 on the bus.
    a = 32'h340;
    for (int k = 0; k < LW; k++) begin
      t.we = 1'b0; t.addr = a + 32'(4 * k); t.be = '0; t.data = '0;
      exp_mem.push_back(t);
    end
    exp_rd.push_back(ref_word(a));
    @(posedge clk); #1;
    core_bus.i_addr = a;
    core_bus.i_re   = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 100) begin
      @(negedge clk);
      if (mem_bus.i_mem_ready && mem_bus.o_mem_re) n++;
      cyc++;
    end
    check("rst_mid_beats_seen", 64'(n), 64'd2);
    @(posedge clk); #1;
    check("rst_mid_beat2_addr", {32'd0, mem_bus.o_mem_addr}, {32'd0, a + 32'd8});
    rst = 1'b1;
    core_bus.i_re = 1'b0;
    #1;
    check("rst_mid_mem_re", {63'd0, mem_bus.o_mem_re}, 64'd0);
    check("rst_mid_busy", {63'd0, core_bus.o_busy}, 64'd0);
    check("rst_mid_mem_addr", {32'd0, mem_bus.o_mem_addr}, 64'd0);
    exp_mem.delete();
    exp_rd.delete();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    do_read(a, b, h);
    check("rst_mid_refill_busy", 64'(b), 64'd5);
    check("rst_mid_refill_miss", {63'd0, h}, 64'd0);

    lat_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      a = (32'($urandom_range(0, 3)) << 10) | (32'(sets_pool[$urandom_range(0, 2)]) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      if (r < 3) do_flush(n);
      else if (r < 40)
        do_write(a, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 4) == 0), wc);
      else do_read(a, b, h);
    end

    repeat (5) @(posedge clk);
    check("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
